// File: rtl/cpu_pc_seq_if.sv
// Flow-control bundle between the instruction decoder (master) and the PC sequencer (slave).
// EN is a plain advance-enable with no back-pressure: when high in RUN the op is consumed at the next edge.
interface cpu_pc_seq_if #(
  parameter int WIDTH = 8
);
  logic             EN;
  logic [2:0]       OP;
  logic             JMP_MODE;
  logic [WIDTH-1:0] TARGET;
  logic             ZERO;
  logic [WIDTH-1:0] PC;
  logic [WIDTH-1:0] BASE;
  logic [2:0]       SP_LEVEL;
  logic             STACK_OVF;
  logic             STACK_UNF;
  logic             HALTED;

  modport master (
    output EN, OP, JMP_MODE, TARGET, ZERO,
    input  PC, BASE, SP_LEVEL, STACK_OVF, STACK_UNF, HALTED
  );

  modport slave (
    input  EN, OP, JMP_MODE, TARGET, ZERO,
    output PC, BASE, SP_LEVEL, STACK_OVF, STACK_UNF, HALTED
  );
endinterface

// File: rtl/cpu_pc_seq.sv
// Program-counter sequencer: owns PC, jump base register and a LIFO return stack,
// stepping once per enabled cycle according to the decoder's 3-bit flow opcode.
module cpu_pc_seq #(
  parameter int WIDTH       = 8,
  parameter int STACK_DEPTH = 4
) (
  input  logic        CLK,
  input  logic        RST,
  cpu_pc_seq_if.slave bus,
  output logic        o_dbg_state
);
  localparam int         SPW   = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
  localparam int         SLOTS = 1 << SPW;
  localparam logic [2:0] DEPTH = 3'(STACK_DEPTH);

  localparam logic [0:0] ST_RUN  = 1'b0;
  localparam logic [0:0] ST_HALT = 1'b1;

  localparam logic [2:0] OP_INC    = 3'b000;
  localparam logic [2:0] OP_JMP    = 3'b001;
  localparam logic [2:0] OP_JZ     = 3'b010;
  localparam logic [2:0] OP_JNZ    = 3'b011;
  localparam logic [2:0] OP_CALL   = 3'b100;
  localparam logic [2:0] OP_RET    = 3'b101;
  localparam logic [2:0] OP_LDBASE = 3'b110;
  localparam logic [2:0] OP_HALT   = 3'b111;

  logic [WIDTH-1:0] r_pc;
  logic [WIDTH-1:0] r_base;
  logic [2:0]       r_sp;
  logic             r_ovf;
  logic             r_unf;
  logic [0:0]       r_state;
  logic [WIDTH-1:0] r_stack [SLOTS];

  logic [WIDTH-1:0] w_pc_inc;
  logic [WIDTH-1:0] w_ea;
  logic [2:0]       w_sp_dec;
  logic [SPW-1:0]   w_push_idx;
  logic [SPW-1:0]   w_top_idx;
  logic [WIDTH-1:0] w_pc_nxt;
  logic [WIDTH-1:0] w_base_nxt;
  logic [2:0]       w_sp_nxt;
  logic             w_ovf_nxt;
  logic             w_unf_nxt;
  logic [0:0]       w_state_nxt;
  logic             w_push;

  // EA uses the base held before this edge, so an LDBASE only affects later jumps.
  assign w_pc_inc   = r_pc + 1'b1;
  assign w_ea       = bus.JMP_MODE ? (r_base + bus.TARGET) : bus.TARGET;
  assign w_sp_dec   = r_sp - 3'd1;
  assign w_push_idx = r_sp[SPW-1:0];
  assign w_top_idx  = w_sp_dec[SPW-1:0];

  always_comb begin
    w_pc_nxt    = r_pc;
    w_base_nxt  = r_base;
    w_sp_nxt    = r_sp;
    w_ovf_nxt   = r_ovf;
    w_unf_nxt   = r_unf;
    w_state_nxt = r_state;
    w_push      = 1'b0;
    if (r_state == ST_RUN && bus.EN) begin
      case (bus.OP)
        OP_INC:    w_pc_nxt = w_pc_inc;
        OP_JMP:    w_pc_nxt = w_ea;
        OP_JZ:     w_pc_nxt = bus.ZERO ? w_ea : w_pc_inc;
        OP_JNZ:    w_pc_nxt = bus.ZERO ? w_pc_inc : w_ea;
        OP_CALL: begin
          if (r_sp < DEPTH) begin
            w_push   = 1'b1;
            w_sp_nxt = r_sp + 3'd1;
            w_pc_nxt = w_ea;
          end else begin
            w_pc_nxt  = w_pc_inc;
            w_ovf_nxt = 1'b1;
          end
        end
        OP_RET: begin
          if (r_sp != 3'd0) begin
            w_pc_nxt = r_stack[w_top_idx];
            w_sp_nxt = w_sp_dec;
          end else begin
            w_pc_nxt  = w_pc_inc;
            w_unf_nxt = 1'b1;
          end
        end
        OP_LDBASE: begin
          w_base_nxt = bus.TARGET;
          w_pc_nxt   = w_pc_inc;
        end
        OP_HALT:   w_state_nxt = ST_HALT;
        default:   w_pc_nxt = r_pc;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_pc    <= '0;
      r_base  <= '0;
      r_sp    <= 3'd0;
      r_ovf   <= 1'b0;
      r_unf   <= 1'b0;
      r_state <= ST_RUN;
    end else begin
      r_pc    <= w_pc_nxt;
      r_base  <= w_base_nxt;
      r_sp    <= w_sp_nxt;
      r_ovf   <= w_ovf_nxt;
      r_unf   <= w_unf_nxt;
      r_state <= w_state_nxt;
    end
  end

  // Stack contents are don't-care after reset; only the level is cleared.
  always_ff @(posedge CLK) begin
    if (!RST && w_push) begin
      r_stack[w_push_idx] <= w_pc_inc;
    end
  end

  assign bus.PC        = r_pc;
  assign bus.BASE      = r_base;
  assign bus.SP_LEVEL  = r_sp;
  assign bus.STACK_OVF = r_ovf;
  assign bus.STACK_UNF = r_unf;
  assign bus.HALTED    = (r_state == ST_HALT);
  assign o_dbg_state   = r_state;
endmodule

// File: tb/tb_cpu_pc_seq.sv
// Self-checking bench for cpu_pc_seq: scripted scenarios plus a randomized run against a reference model.
module tb_cpu_pc_seq;
  localparam logic [2:0] OP_INC    = 3'b000;
  localparam logic [2:0] OP_JMP    = 3'b001;
  localparam logic [2:0] OP_JZ     = 3'b010;
  localparam logic [2:0] OP_JNZ    = 3'b011;
  localparam logic [2:0] OP_CALL   = 3'b100;
  localparam logic [2:0] OP_RET    = 3'b101;
  localparam logic [2:0] OP_LDBASE = 3'b110;
  localparam logic [2:0] OP_HALT   = 3'b111;

  logic clk;
  logic rst;
  logic dbg_state;
  int   errors;
  int   checks;
  logic [7:0] exp_q[$];

  cpu_pc_seq_if #(.WIDTH(8)) bus ();

  cpu_pc_seq #(.WIDTH(8), .STACK_DEPTH(4)) dut (
    .CLK         (clk),
    .RST         (rst),
    .bus         (bus),
    .o_dbg_state (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // driver: apply one cycle of inputs, then sample 1 time unit after the edge
  task automatic drive(input logic en, input logic [2:0] op, input logic mode,
                       input logic [7:0] tgt, input logic z);
    bus.EN       = en;
    bus.OP       = op;
    bus.JMP_MODE = mode;
    bus.TARGET   = tgt;
    bus.ZERO     = z;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive(1'b1, OP_JMP, 1'b0, 8'h99, 1'b0);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    logic [7:0] got;
    do_reset();
    exp_q.push_back(8'h00);
    got = exp_q.pop_front();
    checks++;
    if (bus.PC !== got) begin
      errors++;
      $display("FAIL reset_pc: got %h expected %h", bus.PC, got);
    end
    checks++;
    if ({bus.BASE, bus.SP_LEVEL, bus.STACK_OVF, bus.STACK_UNF, bus.HALTED, dbg_state} !== 15'd0) begin
      errors++;
      $display("FAIL reset_state: base=%h sp=%0d ovf=%b unf=%b halted=%b st=%b expected all zero",
               bus.BASE, bus.SP_LEVEL, bus.STACK_OVF, bus.STACK_UNF, bus.HALTED, dbg_state);
    end
  endtask

  task automatic test_inc_stall();
    logic       en  [5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    logic [7:0] epc [5] = '{8'h01, 8'h02, 8'h03, 8'h03, 8'h03};
    logic [7:0] got;
    for (int i = 0; i < 5; i++) begin
      exp_q.push_back(epc[i]);
      drive(en[i], en[i] ? OP_INC : OP_JMP, 1'b0, 8'h55, 1'b0);
      got = exp_q.pop_front();
      checks++;
      if (bus.PC !== got) begin
        errors++;
        $display("FAIL inc_stall step %0d: pc=%h expected %h", i, bus.PC, got);
      end
    end
    checks++;
    if ({bus.BASE, bus.STACK_OVF, bus.STACK_UNF} !== 10'd0) begin
      errors++;
      $display("FAIL inc_flags: base=%h ovf=%b unf=%b expected 0", bus.BASE, bus.STACK_OVF, bus.STACK_UNF);
    end
  endtask

  task automatic test_jump();
    logic [2:0] op   [4] = '{OP_JMP, OP_LDBASE, OP_JMP, OP_JMP};
    logic       mode [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
    logic [7:0] tgt  [4] = '{8'hA7, 8'h0A, 8'h12, 8'hF8};
    logic [7:0] epc  [4] = '{8'hA7, 8'hA8, 8'h1C, 8'h02};
    logic [7:0] got;
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back(epc[i]);
      drive(1'b1, op[i], mode[i], tgt[i], 1'b0);
      got = exp_q.pop_front();
      checks++;
      if (bus.PC !== got) begin
        errors++;
        $display("FAIL jump step %0d: pc=%h expected %h", i, bus.PC, got);
      end
    end
    checks++;
    if (bus.BASE !== 8'h0A) begin
      errors++;
      $display("FAIL jump_base: base=%h expected 0a", bus.BASE);
    end
  endtask

  task automatic test_cond();
    logic [2:0] op   [5] = '{OP_JZ, OP_JZ, OP_JNZ, OP_JNZ, OP_JZ};
    logic       mode [5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    logic [7:0] tgt  [5] = '{8'h40, 8'h40, 8'h40, 8'h40, 8'h06};
    logic       z    [5] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    logic [7:0] epc  [5] = '{8'h03, 8'h40, 8'h41, 8'h40, 8'h10};
    logic [7:0] got;
    for (int i = 0; i < 5; i++) begin
      exp_q.push_back(epc[i]);
      drive(1'b1, op[i], mode[i], tgt[i], z[i]);
      got = exp_q.pop_front();
      checks++;
      if (bus.PC !== got) begin
        errors++;
        $display("FAIL cond step %0d: pc=%h expected %h", i, bus.PC, got);
      end
    end
  endtask

  task automatic test_call_ret();
    logic [2:0] op  [5] = '{OP_CALL, OP_CALL, OP_RET, OP_RET, OP_RET};
    logic [7:0] tgt [5] = '{8'h20, 8'h30, 8'h00, 8'h00, 8'h00};
    logic [7:0] epc [5] = '{8'h20, 8'h30, 8'h21, 8'h11, 8'h12};
    logic [2:0] esp [5] = '{3'd1, 3'd2, 3'd1, 3'd0, 3'd0};
    logic       eunf[5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    logic [7:0] got;
    for (int i = 0; i < 5; i++) begin
      exp_q.push_back(epc[i]);
      drive(1'b1, op[i], 1'b0, tgt[i], 1'b0);
      got = exp_q.pop_front();
      checks++;
      if ({bus.PC, bus.SP_LEVEL, bus.STACK_UNF, bus.STACK_OVF} !== {got, esp[i], eunf[i], 1'b0}) begin
        errors++;
        $display("FAIL call_ret step %0d: pc=%h sp=%0d unf=%b ovf=%b expected pc=%h sp=%0d unf=%b ovf=0",
                 i, bus.PC, bus.SP_LEVEL, bus.STACK_UNF, bus.STACK_OVF, got, esp[i], eunf[i]);
      end
    end
  endtask

  task automatic test_overflow();
    logic [2:0] op  [13] = '{OP_JMP, OP_CALL, OP_CALL, OP_CALL, OP_CALL, OP_CALL,
                             OP_RET, OP_RET, OP_RET, OP_RET, OP_JMP, OP_CALL, OP_RET};
    logic [7:0] tgt [13] = '{8'h50, 8'h60, 8'h70, 8'h80, 8'h90, 8'hA0,
                             8'h00, 8'h00, 8'h00, 8'h00, 8'hFF, 8'h33, 8'h00};
    logic [7:0] epc [13] = '{8'h50, 8'h60, 8'h70, 8'h80, 8'h90, 8'h91,
                             8'h81, 8'h71, 8'h61, 8'h51, 8'hFF, 8'h33, 8'h00};
    logic [2:0] esp [13] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd4,
                             3'd3, 3'd2, 3'd1, 3'd0, 3'd0, 3'd1, 3'd0};
    logic [7:0] got;
    logic       eovf;
    for (int i = 0; i < 13; i++) begin
      eovf = (i >= 5);
      exp_q.push_back(epc[i]);
      drive(1'b1, op[i], 1'b0, tgt[i], 1'b0);
      got = exp_q.pop_front();
      checks++;
      if ({bus.PC, bus.SP_LEVEL, bus.STACK_OVF, bus.STACK_UNF} !== {got, esp[i], eovf, 1'b1}) begin
        errors++;
        $display("FAIL overflow step %0d: pc=%h sp=%0d ovf=%b unf=%b expected pc=%h sp=%0d ovf=%b unf=1",
                 i, bus.PC, bus.SP_LEVEL, bus.STACK_OVF, bus.STACK_UNF, got, esp[i], eovf);
      end
    end
  endtask

  task automatic test_halt();
    logic       en  [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
    logic [2:0] op  [4] = '{OP_JMP, OP_HALT, OP_JMP, OP_JMP};
    logic [7:0] tgt [4] = '{8'h05, 8'h00, 8'h77, 8'h77};
    logic       eh  [4] = '{1'b0, 1'b1, 1'b1, 1'b1};
    logic [7:0] got;
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back(8'h05);
      drive(en[i], op[i], 1'b0, tgt[i], 1'b0);
      got = exp_q.pop_front();
      checks++;
      if ({bus.PC, bus.HALTED, dbg_state} !== {got, eh[i], eh[i]}) begin
        errors++;
        $display("FAIL halt step %0d: pc=%h halted=%b st=%b expected pc=%h halted=%b",
                 i, bus.PC, bus.HALTED, dbg_state, got, eh[i]);
      end
    end
    do_reset();
    checks++;
    if ({bus.PC, bus.BASE, bus.SP_LEVEL, bus.STACK_OVF, bus.STACK_UNF, bus.HALTED} !== 22'd0) begin
      errors++;
      $display("FAIL halt_reset: pc=%h base=%h sp=%0d ovf=%b unf=%b halted=%b expected all zero",
               bus.PC, bus.BASE, bus.SP_LEVEL, bus.STACK_OVF, bus.STACK_UNF, bus.HALTED);
    end
    exp_q.push_back(8'h01);
    drive(1'b1, OP_INC, 1'b0, 8'h00, 1'b0);
    got = exp_q.pop_front();
    checks++;
    if (bus.PC !== got) begin
      errors++;
      $display("FAIL halt_resume: pc=%h expected %h", bus.PC, got);
    end
  endtask

  task automatic test_random();
    logic [7:0] m_pc, m_base, ea, nxt, got, tgt;
    logic [7:0] m_stk[$];
    logic       m_ovf, m_unf, en, mode, z;
    logic [2:0] op;
    do_reset();
    m_pc = 8'h00; m_base = 8'h00; m_ovf = 1'b0; m_unf = 1'b0;
    m_stk.delete();
    for (int i = 0; i < 300; i++) begin
      en   = ($urandom_range(0, 3) != 0);
      op   = 3'($urandom_range(0, 6));
      mode = 1'($urandom_range(0, 1));
      z    = 1'($urandom_range(0, 1));
      tgt  = 8'($urandom_range(0, 255));
      ea   = mode ? 8'(m_base + tgt) : tgt;
      nxt  = m_pc + 8'd1;
      if (en) begin
        case (op)
          OP_INC:    m_pc = nxt;
          OP_JMP:    m_pc = ea;
          OP_JZ:     m_pc = z ? ea : nxt;
          OP_JNZ:    m_pc = z ? nxt : ea;
          OP_CALL:   if (m_stk.size() < 4) begin m_stk.push_back(nxt); m_pc = ea; end
                     else begin m_pc = nxt; m_ovf = 1'b1; end
          OP_RET:    if (m_stk.size() > 0) m_pc = m_stk.pop_back();
                     else begin m_pc = nxt; m_unf = 1'b1; end
          default: begin m_base = tgt; m_pc = nxt; end
        endcase
      end
      exp_q.push_back(m_pc);
      drive(en, op, mode, tgt, z);
      got = exp_q.pop_front();
      checks++;
      if ({bus.PC, bus.BASE, bus.SP_LEVEL, bus.STACK_OVF, bus.STACK_UNF} !==
          {got, m_base, 3'(m_stk.size()), m_ovf, m_unf}) begin
        errors++;
        $display("FAIL random cycle %0d op=%0d en=%b: pc=%h base=%h sp=%0d ovf=%b unf=%b expected pc=%h base=%h sp=%0d ovf=%b unf=%b",
                 i, op, en, bus.PC, bus.BASE, bus.SP_LEVEL, bus.STACK_OVF, bus.STACK_UNF,
                 got, m_base, m_stk.size(), m_ovf, m_unf);
      end
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    rst = 1'b1;
    bus.EN = 1'b0; bus.OP = OP_INC; bus.JMP_MODE = 1'b0; bus.TARGET = 8'h00; bus.ZERO = 1'b0;
    test_reset();
    test_inc_stall();
    test_jump();
    test_cond();
    test_call_ret();
    test_overflow();
    test_halt();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/cpu_pc_seq.md
Name: cpu_pc_seq

Overview:
Program-counter sequencer for the one-cycle CPU. It owns the PC, the jump base register and a small call/return stack, and decodes a 3-bit flow opcode from the instruction decoder each cycle. Jump targets are absolute or base-relative (BASE + offset), the same two addressing modes as the jump unit. The PC output drives program-memory addressing.

Parameters:
WIDTH, 8, address/PC/base width in bits
STACK_DEPTH, 4, return-stack entries; legal range 1..7

Ports:
CLK  input  1  system clock, all state updates on rising edge
RST  input  1  synchronous, active-high reset
EN  input  1  advance enable; 0 = stall, all state holds
OP  input  3  flow opcode: 000 INC, 001 JMP, 010 JZ, 011 JNZ, 100 CALL, 101 RET, 110 LDBASE, 111 HALT
JMP_MODE  input  1  0 = absolute target, 1 = base-relative target
TARGET  input  WIDTH  jump target/offset; LDBASE data
ZERO  input  1  ALU zero flag for JZ/JNZ
PC  output  WIDTH  current program counter (registered)
BASE  output  WIDTH  current base register (registered)
SP_LEVEL  output  3  number of valid stack entries (0..STACK_DEPTH)
STACK_OVF  output  1  sticky: CALL attempted with stack full
STACK_UNF  output  1  sticky: RET attempted with stack empty
HALTED  output  1  high in HALT state

Behaviour:
- Reset (RST=1 at CLK edge, priority over EN): PC=0, BASE=0, SP_LEVEL=0, STACK_OVF=0, STACK_UNF=0, HALTED=0, state RUN; stack contents don't-care. Reset mid-operation (incl. in HALT) fully reinitialises.
- All outputs are registered. An op presented in cycle n takes effect on PC/BASE/flags at the edge ending cycle n. Outputs are visible in cycle n+1.
- Effective address EA = JMP_MODE ? (BASE + TARGET) mod 2^WIDTH : TARGET. BASE is the value before this cycle's edge.
- PC+1 wraps from 2^WIDTH-1 to 0.
- FSM states: RUN, HALT. In HALT, all state holds regardless of OP/EN until RST.
- In RUN with EN=0, all state holds and OP is ignored.
- In RUN with EN=1, per OP:
  - INC: PC<=PC+1.
  - JMP: PC<=EA.
  - JZ: PC<=ZERO ? EA : PC+1.
  - JNZ: PC<=ZERO ? PC+1 : EA.
  - CALL: if SP_LEVEL<STACK_DEPTH, push PC+1, SP_LEVEL+1, PC<=EA. If SP_LEVEL==STACK_DEPTH, no push, PC<=PC+1, STACK_OVF<=1.
  - RET: if SP_LEVEL>0, PC<=top entry, SP_LEVEL-1. If SP_LEVEL==0, PC<=PC+1, STACK_UNF<=1.
  - LDBASE: BASE<=TARGET, PC<=PC+1. The new BASE applies to EA from the next cycle.
  - HALT: PC holds, state->HALT, HALTED<=1.
- Stack is LIFO. The pushed return address is PC+1 with wrap (CALL at PC=FF pushes 00).
- STACK_OVF and STACK_UNF clear only on reset.

Test Plan:
- Reset then 3 INC cycles -> PC 00,01,02,03; BASE=00; flags 0. With EN=0 for 2 cycles, PC holds at 03.
- Absolute JMP TARGET=A7 -> PC=A7. Then LDBASE TARGET=0A (PC=A8), then JMP_MODE=1 JMP TARGET=12 -> PC=1C. Then JMP_MODE=1 TARGET=F8 -> PC=02 (wrap).
- JZ TARGET=40 with ZERO=0 -> PC+1; with ZERO=1 -> PC=40. JNZ gives the mirror results.
- From PC=10, CALL 20 -> PC=20, SP_LEVEL=1. CALL 30 -> PC=30, SP_LEVEL=2. RET -> PC=21. RET -> PC=11, SP_LEVEL=0. Another RET -> PC=12, STACK_UNF=1.
- With STACK_DEPTH=4, issue 5 CALLs -> 5th does not jump (PC+1), STACK_OVF=1, SP_LEVEL stays 4. Four RETs return addresses in reverse order.
- HALT at PC=05 -> HALTED=1, PC stays 05 while JMP ops are applied. RST -> all outputs 0, INC resumes from 00.
